// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL
  } icache_state_t;

  localparam int unsigned DefAddrW = 32;

  typedef logic [DefAddrW-1:0] line_addr_t;

  function automatic int unsigned calc_offset_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned calc_index_w(input int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  // The 2 accounts for the ignored byte-within-word bits.
  function automatic int unsigned calc_tag_w(input int unsigned addr_w,
                                             input int unsigned line_words,
                                             input int unsigned num_sets);
    return addr_w - calc_offset_w(line_words) - calc_index_w(num_sets) - 2;
  endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Refill sequencer: owns the IDLE/REQ/FILL state, beat counter, latched line address and
// the poison flag that stops a flushed in-flight line from being validated.
module icache_refill_fsm
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned OFFSET_W   = calc_offset_w(LINE_WORDS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                miss_start_i,
  input  logic [ADDR_W-1:0]   miss_line_addr_i,
  input  logic                flush_i,
  input  logic                mem_req_ready_i,
  input  logic                mem_rvalid_i,
  output logic [OFFSET_W-1:0] beat_cnt_o,
  output logic [ADDR_W-1:0]   line_addr_o,
  output logic                poison_o,
  output logic                mem_req_valid_o,
  output logic                busy_o,
  output logic                fill_we_o,
  output logic                fill_last_o
);

  localparam logic [OFFSET_W-1:0] LastBeat = OFFSET_W'(LINE_WORDS - 1);

  icache_state_t       state_q;
  logic [OFFSET_W-1:0] beat_cnt_q;
  logic [ADDR_W-1:0]   line_addr_q;
  logic                poison_q;
  logic                mem_req_valid_q;
  logic                busy_q;
  logic                last_beat;

  assign last_beat = (beat_cnt_q == LastBeat);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      beat_cnt_q      <= '0;
      line_addr_q     <= '0;
      poison_q        <= 1'b0;
      mem_req_valid_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_start_i) begin
            state_q         <= REQ;
            line_addr_q     <= miss_line_addr_i;
            poison_q        <= 1'b0;
            mem_req_valid_q <= 1'b1;
            busy_q          <= 1'b1;
          end
        end
        REQ: begin
          if (mem_req_ready_i) begin
            state_q         <= FILL;
            beat_cnt_q      <= '0;
            mem_req_valid_q <= 1'b0;
          end
        end
        FILL: begin
          if (mem_rvalid_i) begin
            if (last_beat) begin
              state_q    <= IDLE;
              beat_cnt_q <= '0;
              busy_q     <= 1'b0;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      // A flush while the line is in flight means its data may predate the fence.
      if (flush_i && (state_q != IDLE)) begin
        poison_q <= 1'b1;
      end
    end
  end

  assign fill_we_o       = (state_q == FILL) && mem_rvalid_i;
  assign fill_last_o     = fill_we_o && last_beat;
  assign beat_cnt_o      = beat_cnt_q;
  assign line_addr_o     = line_addr_q;
  assign poison_o        = poison_q;
  assign mem_req_valid_o = mem_req_valid_q;
  assign busy_o          = busy_q;

endmodule

// File: rtl/icache_dm_refill.sv
// Direct-mapped instruction cache with same-cycle hits and multi-beat line refill.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_dm_refill
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned NUM_SETS   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req_valid,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_resp_instr,
  input  logic              flush,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned OFFSET_W = calc_offset_w(LINE_WORDS);
  localparam int unsigned INDEX_W  = calc_index_w(NUM_SETS);
  localparam int unsigned TAG_W    = calc_tag_w(ADDR_W, LINE_WORDS, NUM_SETS);
  localparam int unsigned IDX_LSB  = OFFSET_W + 2;

  logic [OFFSET_W-1:0] req_off;
  logic [INDEX_W-1:0]  req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [ADDR_W-1:0]   miss_line_addr;

  logic [ADDR_W-1:0]   fill_line_addr;
  logic [INDEX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]    fill_tag;
  logic [OFFSET_W-1:0] beat_cnt;
  logic                poison;
  logic                fill_we;
  logic                fill_last;

  logic                lookup_hit;
  logic                miss_start;

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [DATA_W-1:0]   data_q [NUM_SETS][LINE_WORDS];

  assign req_off        = cpu_addr[2 +: OFFSET_W];
  assign req_idx        = cpu_addr[IDX_LSB +: INDEX_W];
  assign req_tag        = cpu_addr[ADDR_W-1 -: TAG_W];
  assign miss_line_addr = {req_tag, req_idx, {IDX_LSB{1'b0}}};

  assign fill_idx = fill_line_addr[IDX_LSB +: INDEX_W];
  assign fill_tag = fill_line_addr[ADDR_W-1 -: TAG_W];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[1:0], fill_line_addr[IDX_LSB-1:0]};

  assign lookup_hit     = !busy && cpu_req_valid && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign cpu_resp_valid = lookup_hit && !flush;
  assign cpu_resp_instr = cpu_resp_valid ? data_q[req_idx][req_off] : '0;
  // A flush-cycle lookup is a miss too; the refill lands after the valid bits clear.
  assign miss_start     = !busy && cpu_req_valid && !cpu_resp_valid;

  assign mem_req_addr = fill_line_addr;

  icache_refill_fsm #(
    .ADDR_W    (ADDR_W),
    .LINE_WORDS(LINE_WORDS),
    .OFFSET_W  (OFFSET_W)
  ) u_refill_fsm (
    .clk_i           (clock),
    .rst_ni          (reset),
    .miss_start_i    (miss_start),
    .miss_line_addr_i(miss_line_addr),
    .flush_i         (flush),
    .mem_req_ready_i (mem_req_ready),
    .mem_rvalid_i    (mem_rvalid),
    .beat_cnt_o      (beat_cnt),
    .line_addr_o     (fill_line_addr),
    .poison_o        (poison),
    .mem_req_valid_o (mem_req_valid),
    .busy_o          (busy),
    .fill_we_o       (fill_we),
    .fill_last_o     (fill_last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (fill_last && !poison) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (fill_we) begin
      data_q[fill_idx][beat_cnt] <= mem_rdata;
    end
    if (fill_last) begin
      tag_q[fill_idx] <= fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (cpu_resp_valid && (hit_count_q != '1)) begin
        hit_count_q <= hit_count_q + 32'd1;
      end
      if (miss_start && (miss_count_q != '1)) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_dm_refill.sv
// Directed bench for icache_dm_refill (default geometry: 4-word lines, 16 sets).
module tb_icache_dm_refill;
  import icache_pkg::*;

  logic        clock;
  logic        reset;
  logic        cpu_req_valid;
  logic [31:0] cpu_addr;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_instr;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int tests = 0;
  int fails = 0;

  icache_dm_refill dut (
    .clock         (clock),
    .reset         (reset),
    .cpu_req_valid (cpu_req_valid),
    .cpu_addr      (cpu_addr),
    .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_instr(cpu_resp_instr),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .busy          (busy)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_hit(input line_addr_t a, input logic [31:0] exp);
    cpu_req_valid = 1'b1;
    cpu_addr      = a;
    #1;
    check("hit_valid", {31'd0, cpu_resp_valid}, 32'd1);
    check("hit_instr", cpu_resp_instr, exp);
    step();
  endtask

  task automatic start_miss(input line_addr_t a);
    cpu_req_valid = 1'b1;
    cpu_addr      = a;
    #1;
    check("miss_valid", {31'd0, cpu_resp_valid}, 32'd0);
    step();
  endtask

  // Memory side: ready after two stall cycles, then one beat per cycle.
  task automatic refill(input line_addr_t a, input logic [31:0] base, input int flush_beat,
                        input line_addr_t redir);
    int waitc = 0;
    while (mem_req_valid !== 1'b1 && waitc < 8) begin
      step();
      waitc++;
    end
    check("req_valid", {31'd0, mem_req_valid}, 32'd1);
    check("req_addr", mem_req_addr, a);
    check("busy_req", {31'd0, busy}, 32'd1);
    repeat (2) begin
      step();
      check("req_hold_valid", {31'd0, mem_req_valid}, 32'd1);
      check("req_hold_addr", mem_req_addr, a);
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check("fill_req_drop", {31'd0, mem_req_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = base + 32'(i);
      flush      = (i == flush_beat);
      if (i == 2 && redir != '0) cpu_addr = redir;
      #1;
      check("fill_no_resp", {31'd0, cpu_resp_valid}, 32'd0);
      step();
    end
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    flush      = 1'b0;
    check("busy_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset         = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_addr      = '0;
    flush         = 1'b0;
    mem_req_ready = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
    #1;
    check("rst_resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
    check("rst_resp_instr", cpu_resp_instr, 32'd0);
    check("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rst_req_addr", mem_req_addr, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    step();
    step();
    reset = 1'b1;

    // Cold miss, then same-line hits
    start_miss(32'h40);
    refill(32'h40, 32'hA0, -1, '0);
    expect_hit(32'h40, 32'hA0);
    expect_hit(32'h44, 32'hA1);
    check("hit_no_req", {31'd0, mem_req_valid}, 32'd0);
    expect_hit(32'h48, 32'hA2);
    expect_hit(32'h4C, 32'hA3);

    // Conflict on index 4
    start_miss(32'h140);
    refill(32'h140, 32'hB0, -1, '0);
    expect_hit(32'h140, 32'hB0);
    start_miss(32'h40);
    refill(32'h40, 32'hC0, -1, '0);
    expect_hit(32'h44, 32'hC1);

    // Redirect mid-FILL: 0x80 completes, then 0x200 misses
    start_miss(32'h80);
    refill(32'h80, 32'hD0, -1, 32'h200);
    start_miss(32'h200);
    refill(32'h200, 32'hE0, -1, '0);
    expect_hit(32'h200, 32'hE0);
    expect_hit(32'h84, 32'hD1);

    // Flush on beat 2: line completes but stays invalid
    start_miss(32'hC0);
    refill(32'hC0, 32'hF0, 2, '0);
    start_miss(32'hC0);
    refill(32'hC0, 32'h10, -1, '0);
    expect_hit(32'hC0, 32'h10);

    // Flush coinciding with the last beat
    start_miss(32'h300);
    refill(32'h300, 32'h20, 3, '0);
    start_miss(32'h300);
    refill(32'h300, 32'h30, -1, '0);
    expect_hit(32'h300, 32'h30);

    // Flush in IDLE on a resident line
    start_miss(32'h40);
    refill(32'h40, 32'h50, -1, '0);
    expect_hit(32'h40, 32'h50);
    cpu_addr = 32'h40;
    flush    = 1'b1;
    #1;
    check("flush_idle_valid", {31'd0, cpu_resp_valid}, 32'd0);
    check("flush_idle_instr", cpu_resp_instr, 32'd0);
    step();
    flush = 1'b0;
    refill(32'h40, 32'h60, -1, '0);
    expect_hit(32'h40, 32'h60);

    // No request: no lookup, no miss; stray rvalid in IDLE ignored
    cpu_req_valid = 1'b0;
    mem_rvalid    = 1'b1;
    mem_rdata     = 32'hDEAD_BEEF;
    #1;
    check("noreq_valid", {31'd0, cpu_resp_valid}, 32'd0);
    step();
    mem_rvalid = 1'b0;
    check("noreq_no_miss", {31'd0, mem_req_valid}, 32'd0);
    check("noreq_busy", {31'd0, busy}, 32'd0);
    expect_hit(32'h40, 32'h60);

`ifdef ICACHE_STATS_EN
    check("hit_count", hit_count, 32'd13);
    check("miss_count", miss_count, 32'd11);
    force dut.hit_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.hit_count_q;
    expect_hit(32'h40, 32'h60);
    check("hit_count_sat", hit_count, 32'hFFFF_FFFF);
    check("miss_count_hold", miss_count, 32'd11);
`endif

    // Asynchronous reset mid-REQ
    start_miss(32'h500);
    check("pre_rst_req", {31'd0, mem_req_valid}, 32'd1);
    reset = 1'b0;
    #1;
    check("arst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("arst_req_addr", mem_req_addr, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
`ifdef ICACHE_STATS_EN
    check("arst_hit_count", hit_count, 32'd0);
    check("arst_miss_count", miss_count, 32'd0);
`endif
    cpu_req_valid = 1'b0;
    step();
    reset = 1'b1;
    cpu_req_valid = 1'b1;
    cpu_addr      = 32'h40;
    #1;
    check("arst_invalid", {31'd0, cpu_resp_valid}, 32'd0);
    step();
    cpu_req_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
